adder_share_ctrl: RTL and testbench

Nibble-serial adder controller that shares one 4-bit ripple-carry add stage between two requesters. Each accepted request adds two `4*NIBBLES`-bit operands plus carry-in, one nibble per cycle, LSB nibble first, with a registered carry between nibbles. It returns the sum, carry-out and requester ID on a valid/ready response channel. The block sits between two operand producers and one result consumer, so a single small adder serves multi-nibble arithmetic.

---
 rtl/adder_share_ctrl.sv | 156 +++++++++++++++
 tb/tb_adder_share_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Nibble-serial adder shared by two requesters: round-robin grant, one nibble per cycle, valid/ready response.
// Optional ADDER_SHARE_OVF_EN adds a registered signed-overflow output rsp_ovf.
module adder_share_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  input  logic                   req1_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_id,
`ifdef ADDER_SHARE_OVF_EN
  output logic                   rsp_ovf,
`endif
  output logic                   busy
);

  // state | meaning
  // IDLE  | arbitrating; ready offered to the granted requester
  // RUN   | adding nibble r_idx each cycle, LSB nibble first
  // DONE  | result held on the response channel until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          r_state;
  logic            r_prio;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_id;
  logic            r_rsp_valid;
  logic            r_busy;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_idle;
  logic            w_last;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [4:0]      w_sum;

  assign w_idle = (r_state == S_IDLE);
  assign w_gnt0 = req0_valid & (~req1_valid | ~r_prio);
  assign w_gnt1 = req1_valid & (~req0_valid |  r_prio);
  assign w_last = (r_idx == IW'(NIBBLES - 1));

  // Ready is suppressed during reset so no operand is taken on a reset cycle.
  assign req0_ready = w_idle & ~rst & w_gnt0;
  assign req1_ready = w_idle & ~rst & w_gnt1;

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IW'(n)) begin
        w_a_nib = r_a[n*4 +: 4];
        w_b_nib = r_b[n*4 +: 4];
      end
    end
  end

  assign w_sum = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};

`ifdef ADDER_SHARE_OVF_EN
  logic       r_ovf;
  logic [3:0] w_lo;

  // Carry into the MSB bit of the final nibble, needed for signed overflow.
  assign w_lo = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, r_carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= w_lo[3] ^ w_sum[4];
    end
  end

  assign rsp_ovf = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_a     <= w_gnt1 ? req1_a   : req0_a;
            r_b     <= w_gnt1 ? req1_b   : req0_b;
            r_carry <= w_gnt1 ? req1_cin : req0_cin;
            r_id    <= w_gnt1;
            r_prio  <= ~w_gnt1;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) r_sum[n*4 +: 4] <= w_sum[3:0];
          end
          r_carry <= w_sum[4];
          if (w_last) begin
            r_cout      <= w_sum[4];
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_id    = r_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl (NIBBLES=4): vector table, scoreboard queue, corner sequences.
// Build with ADDER_SHARE_OVF_EN defined to also check rsp_ovf.
module tb_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [15:0] rsp_sum;
`ifdef ADDER_SHARE_OVF_EN
  logic        rsp_ovf;
`endif

  adder_share_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
`ifdef ADDER_SHARE_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide addition, independent of the nibble-serial datapath.
  function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t e;
    logic [16:0] s;
    s      = {1'b0, a} + {1'b0, b} + {16'h0, cin};
    e.id   = id;
    e.sum  = s[15:0];
    e.cout = s[16];
    e.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !prev_rst && prev_v && !prev_r) check("valid_hold", {31'b0, rsp_valid}, 32'd1);
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("rsp_sum",  {16'b0, rsp_sum},  {16'b0, e.sum});
        check("rsp_cout", {31'b0, rsp_cout}, {31'b0, e.cout});
        check("rsp_id",   {31'b0, rsp_id},   {31'b0, e.id});
`ifdef ADDER_SHARE_OVF_EN
        check("rsp_ovf",  {31'b0, rsp_ovf},  {31'b0, e.ovf});
`endif
      end
    end
    prev_v   <= rsp_valid;
    prev_r   <= rsp_ready;
    prev_rst <= rst;
  end

  // Called just after a rising edge; returns just after the handshake edge with t = handshake cycle.
  task automatic send(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin, output int t);
    int  n;
    bit  done;
    t = -1; n = 0; done = 0;
    if (id == 1'b0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
    else            begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
    while (!done && n < 40) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        done = 1;
        t = cyc;
      end
      n++;
    end
    if (!done) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    // Scramble operands after handshake; the DUT must have sampled them already.
    if (id == 1'b0) begin req0_valid = 0; req0_a = ~a; req0_b = ~b; req0_cin = ~cin; end
    else            begin req1_valid = 0; req1_a = ~a; req1_b = ~b; req1_cin = ~cin; end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    vec_t vt[8];
    exp_t e;
    int   t, t2, n, lat, g;
    int   gid[4];
    int   gcyc[4];
    logic [15:0] a0, b0, a1, b1;
    logic        c0, c1;

    vt[0] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[2] = '{1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[3] = '{1'b0, 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
    vt[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[6] = '{1'b1, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vt[7] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst = 1; rsp_ready = 0;
    req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h3333; req1_b = 16'h4444; req1_cin = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    check("rst_rsp_valid",  {31'b0, rsp_valid},  32'd0);
    check("rst_rsp_sum",    {16'b0, rsp_sum},    32'd0);
    check("rst_rsp_cout",   {31'b0, rsp_cout},   32'd0);
    check("rst_rsp_id",     {31'b0, rsp_id},     32'd0);
    check("rst_busy",       {31'b0, busy},       32'd0);
`ifdef ADDER_SHARE_OVF_EN
    check("rst_rsp_ovf",    {31'b0, rsp_ovf},    32'd0);
`endif
    @(posedge clk); #1;
    rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;

    // Single add and response latency.
    send(1'b0, 16'h1234, 16'h0FFF, 1'b0, t);
    q.push_back('{1'b0, 16'h2233, 1'b0, 1'b0});
    lat = -1; n = 0;
    while (lat < 0 && n < 20) begin
      @(negedge clk);
      if (rsp_valid) lat = cyc - t;
      n++;
    end
    check("first_latency", lat, 32'd5);
    drain();

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      send(vt[i].id, vt[i].a, vt[i].b, vt[i].cin, t);
      q.push_back('{vt[i].id, vt[i].sum, vt[i].cout, vt[i].ovf});
      drain();
    end

    // Fairness with both requesters always pending.
    do_reset();
    rsp_ready = 1;
    a0 = 16'($urandom_range(0, 65535)); b0 = 16'($urandom_range(0, 65535)); c0 = 1'($urandom_range(0, 1));
    a1 = 16'($urandom_range(0, 65535)); b1 = 16'($urandom_range(0, 65535)); c1 = 1'($urandom_range(0, 1));
    req0_valid = 1; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = 1; req1_a = a1; req1_b = b1; req1_cin = c1;
    g = 0; n = 0;
    while (g < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (req0_ready && req1_ready) check("both_ready", 32'd1, 32'd0);
      if (req0_ready || req1_ready) begin
        gid[g]  = req1_ready ? 1 : 0;
        gcyc[g] = cyc;
        if (req1_ready) q.push_back(model(1'b1, a1, b1, c1));
        else            q.push_back(model(1'b0, a0, b0, c0));
        @(posedge clk); #1;
        if (gid[g] == 1) begin
          a1 = 16'($urandom_range(0, 65535)); b1 = 16'($urandom_range(0, 65535)); c1 = 1'($urandom_range(0, 1));
          req1_a = a1; req1_b = b1; req1_cin = c1;
        end else begin
          a0 = 16'($urandom_range(0, 65535)); b0 = 16'($urandom_range(0, 65535)); c0 = 1'($urandom_range(0, 1));
          req0_a = a0; req0_b = b0; req0_cin = c0;
        end
        g++;
      end else begin
        @(posedge clk); #1;
      end
    end
    req0_valid = 0; req1_valid = 0;
    check("fair_grant_count", g, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g) check("fair_grant_id", gid[i], i % 2);
      if (i > 0 && i < g) check("fair_spacing", gcyc[i] - gcyc[i-1], 32'd6);
    end
    drain();

    // Backpressure: hold the result for three DONE cycles.
    rsp_ready = 0;
    send(1'b0, 16'h4321, 16'h1111, 1'b1, t);
    q.push_back(model(1'b0, 16'h4321, 16'h1111, 1'b1));
    req0_valid = 1; req1_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", {31'b0, rsp_valid},  32'd1);
      check("bp_sum",   {16'b0, rsp_sum},    32'h5433);
      check("bp_id",    {31'b0, rsp_id},     32'd0);
      check("bp_busy",  {31'b0, busy},       32'd1);
      check("bp_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1; req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp_release_busy",  {31'b0, busy},      32'd0);
    check("bp_queue_empty",   q.size(),           32'd0);
    @(posedge clk); #1;

    // Reset after two nibbles: no response, prio back to 0.
    send(1'b0, 16'h5555, 16'h5A5A, 1'b1, t);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_sum",   {16'b0, rsp_sum},   32'd0);
    check("mid_rst_cout",  {31'b0, rsp_cout},  32'd0);
    check("mid_rst_busy",  {31'b0, busy},      32'd0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 16'h0F0F; req0_b = 16'h0101; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h2020; req1_b = 16'h0303; req1_cin = 1;
    @(negedge clk);
    check("post_rst_grant", {30'b0, req0_ready, req1_ready}, 32'd2);
    if (req0_ready) q.push_back(model(1'b0, 16'h0F0F, 16'h0101, 1'b0));
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drain();

`ifdef ADDER_SHARE_OVF_EN
    send(1'b0, 16'h7FFF, 16'h0001, 1'b0, t);
    q.push_back('{1'b0, 16'h8000, 1'b0, 1'b1});
    drain();
    send(1'b1, 16'hFFFF, 16'h0001, 1'b0, t2);
    q.push_back('{1'b1, 16'h0000, 1'b1, 1'b0});
    drain();
`endif

    check("final_queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
